// File: rtl/id_ex_control_if.sv
// Signals between the IF/ID stage and the ID/EX control register.
// The slave side is the decode/ID-EX stage; the master side drives the ID inputs.
interface id_ex_control_if;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 11;
    localparam int unsigned REG_W   = 5;

    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic               flush;
    logic               stall;
    logic               ex_valid;
    logic [1:0]         ex_ALUOp;
    logic [OP_W-1:0]    ex_ins;
    logic               ex_ALUSrc;
    logic               ex_MemRead;
    logic               ex_MemWrite;
    logic               ex_MemToReg;
    logic               ex_RegWrite;
    logic               ex_SetFlags;
    logic               ex_Branch;
    logic               ex_UncondBr;
    logic [REG_W-1:0]   ex_Rd;
    logic [REG_W-1:0]   ex_Rn;
    logic [REG_W-1:0]   ex_Rm;
    logic               ex_illegal;

    modport master (
        output id_valid, id_instr, flush,
        input  stall, ex_valid, ex_ALUOp, ex_ins, ex_ALUSrc, ex_MemRead, ex_MemWrite,
               ex_MemToReg, ex_RegWrite, ex_SetFlags, ex_Branch, ex_UncondBr,
               ex_Rd, ex_Rn, ex_Rm, ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, flush,
        output stall, ex_valid, ex_ALUOp, ex_ins, ex_ALUSrc, ex_MemRead, ex_MemWrite,
               ex_MemToReg, ex_RegWrite, ex_SetFlags, ex_Branch, ex_UncondBr,
               ex_Rd, ex_Rn, ex_Rm, ex_illegal
    );
endinterface

// File: rtl/id_ex_control.sv
// LEGv8 decode and ID/EX pipeline register: main control decode, load-use
// hazard detection with one-cycle stall, bubble insertion and branch flush.
module id_ex_control #(
    parameter int unsigned XZR = 31
) (
    input  logic            clk,
    input  logic            reset,
    id_ex_control_if.slave  bus
);

    localparam int unsigned OP_W  = 11;
    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [1:0]       aluop;
        logic [OP_W-1:0]  ins;
        logic             alusrc;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
        logic             regwrite;
        logic             setflags;
        logic             branch;
        logic             uncondbr;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rn;
        logic [REG_W-1:0] rm;
        logic             illegal;
    } ex_t;

    ex_t ex_q;
    ex_t ex_d;
    ex_t dec;

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm_sel;
    logic             is_r, is_i, is_ldur, is_stur, is_cbz, is_b, set_flags;
    logic             use_rn, use_rm, hazard;
    logic             unused_instr_bits;

    assign op                = bus.id_instr[31:21];
    assign rn                = bus.id_instr[9:5];
    assign unused_instr_bits = ^bus.id_instr[15:10];

    // Opcode classification
    always_comb begin
        is_r      = 1'b0;
        is_i      = 1'b0;
        is_ldur   = 1'b0;
        is_stur   = 1'b0;
        is_cbz    = 1'b0;
        is_b      = 1'b0;
        set_flags = 1'b0;
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000, 11'b11001010000: is_r = 1'b1;
            11'b10101011000, 11'b11101011000: begin
                is_r      = 1'b1;
                set_flags = 1'b1;
            end
            11'b1001000100?, 11'b1101000100?,
            11'b1001001000?, 11'b1011001000?, 11'b1101001000?: is_i = 1'b1;
            11'b1011000100?, 11'b1111000100?: begin
                is_i      = 1'b1;
                set_flags = 1'b1;
            end
            11'b11111000010: is_ldur = 1'b1;
            11'b11111000000: is_stur = 1'b1;
            11'b10110100???: is_cbz  = 1'b1;
            11'b000101?????: is_b    = 1'b1;
            default: ;
        endcase
    end

    // STUR and CBZ read Rt from [4:0]; only R-type takes Rm from [20:16]
    assign rm_sel = is_r ? bus.id_instr[20:16] : bus.id_instr[4:0];
    assign use_rn = is_r | is_i | is_ldur | is_stur;
    assign use_rm = is_r | is_stur | is_cbz;

    assign hazard = bus.id_valid & ex_q.valid & ex_q.memread
                  & (ex_q.rd != REG_W'(XZR))
                  & ((use_rn & (rn == ex_q.rd)) | (use_rm & (rm_sel == ex_q.rd)));

    assign bus.stall = hazard & ~bus.flush & ~reset;

    // Decoded control word and next EX contents
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.ins      = op;
        dec.rd       = bus.id_instr[4:0];
        dec.rn       = rn;
        dec.rm       = rm_sel;
        dec.aluop    = (is_r | is_i)   ? 2'b10 :
                       (is_cbz | is_b) ? 2'b01 : 2'b00;
        dec.alusrc   = is_i | is_ldur | is_stur;
        dec.memread  = is_ldur;
        dec.memwrite = is_stur;
        dec.memtoreg = is_ldur;
        dec.regwrite = is_r | is_i | is_ldur;
        dec.setflags = set_flags;
        dec.branch   = is_cbz;
        dec.uncondbr = is_b;
        dec.illegal  = ~(is_r | is_i | is_ldur | is_stur | is_cbz | is_b);

        ex_d = '0;
        if (!bus.flush && !hazard && bus.id_valid) begin
            ex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_ALUOp    = ex_q.aluop;
    assign bus.ex_ins      = ex_q.ins;
    assign bus.ex_ALUSrc   = ex_q.alusrc;
    assign bus.ex_MemRead  = ex_q.memread;
    assign bus.ex_MemWrite = ex_q.memwrite;
    assign bus.ex_MemToReg = ex_q.memtoreg;
    assign bus.ex_RegWrite = ex_q.regwrite;
    assign bus.ex_SetFlags = ex_q.setflags;
    assign bus.ex_Branch   = ex_q.branch;
    assign bus.ex_UncondBr = ex_q.uncondbr;
    assign bus.ex_Rd       = ex_q.rd;
    assign bus.ex_Rn       = ex_q.rn;
    assign bus.ex_Rm       = ex_q.rm;
    assign bus.ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_control.sv
// Bench for id_ex_control: per-cycle expected EX contents are queued when the
// ID inputs are applied and compared one edge later; stall is checked in-cycle.
module tb_id_ex_control;

    typedef struct packed {
        logic        valid;
        logic [1:0]  aluop;
        logic [10:0] ins;
        logic        alusrc;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        regwrite;
        logic        setflags;
        logic        branch;
        logic        uncondbr;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic        illegal;
    } ex_t;

    typedef struct packed {
        ex_t val;
        ex_t mask;
    } sb_t;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [31:0] instr;
        logic        fl;
        logic        hz;
    } step_t;

    localparam logic [31:0] I_ADD   = 32'h8B030041;
    localparam logic [31:0] I_LDUR  = 32'hF8400041;
    localparam logic [31:0] I_ADD45 = 32'h8B050024;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    sb_t  sb[$];
    ex_t  obs;

    id_ex_control_if ifc();

    id_ex_control #(.XZR(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {ifc.ex_valid, ifc.ex_ALUOp, ifc.ex_ins, ifc.ex_ALUSrc, ifc.ex_MemRead,
                  ifc.ex_MemWrite, ifc.ex_MemToReg, ifc.ex_RegWrite, ifc.ex_SetFlags,
                  ifc.ex_Branch, ifc.ex_UncondBr, ifc.ex_Rd, ifc.ex_Rn, ifc.ex_Rm,
                  ifc.ex_illegal};

    // Reference decode straight from the opcode table
    function automatic ex_t model(input logic [31:0] w);
        ex_t         e;
        logic [10:0] op;
        op = w[31:21];
        e = '0;
        e.valid = 1'b1;
        e.ins   = op;
        e.rd    = w[4:0];
        e.rn    = w[9:5];
        e.rm    = w[4:0];
        if (op == 11'b10001011000 || op == 11'b10101011000 || op == 11'b11001011000 ||
            op == 11'b11101011000 || op == 11'b10001010000 || op == 11'b10101010000 ||
            op == 11'b11001010000) begin
            e.aluop = 2'b10; e.regwrite = 1'b1; e.rm = w[20:16];
            e.setflags = (op == 11'b10101011000) || (op == 11'b11101011000);
        end else if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1011000100 ||
                     op[10:1] == 10'b1101000100 || op[10:1] == 10'b1111000100 ||
                     op[10:1] == 10'b1001001000 || op[10:1] == 10'b1011001000 ||
                     op[10:1] == 10'b1101001000) begin
            e.aluop = 2'b10; e.alusrc = 1'b1; e.regwrite = 1'b1;
            e.setflags = (op[10:1] == 10'b1011000100) || (op[10:1] == 10'b1111000100);
        end else if (op == 11'b11111000010) begin
            e.alusrc = 1'b1; e.memread = 1'b1; e.memtoreg = 1'b1; e.regwrite = 1'b1;
        end else if (op == 11'b11111000000) begin
            e.alusrc = 1'b1; e.memwrite = 1'b1;
        end else if (w[31:24] == 8'b10110100) begin
            e.aluop = 2'b01; e.branch = 1'b1;
        end else if (w[31:26] == 6'b000101) begin
            e.aluop = 2'b01; e.uncondbr = 1'b1;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // Drive one ID cycle and queue what EX must hold after the next edge
    task automatic apply(input step_t s);
        sb_t item;
        reset        = s.rst;
        ifc.id_valid = s.v;
        ifc.id_instr = s.instr;
        ifc.flush    = s.fl;
        item.mask = '1;
        item.val  = '0;
        if (!s.rst) begin
            if (s.fl || s.hz || !s.v) begin
                item.mask.ins = '0;
                item.mask.rd  = '0;
                item.mask.rn  = '0;
                item.mask.rm  = '0;
            end else begin
                item.val = model(s.instr);
            end
        end
        sb.push_back(item);
    endtask

    task automatic test_reset();
        step_t s[4];
        sb_t   e;
        s = '{'{1'b1, 1'b1, I_ADD, 1'b0, 1'b0}, '{1'b1, 1'b1, I_ADD, 1'b0, 1'b0},
              '{1'b0, 1'b1, I_ADD, 1'b0, 1'b0}, '{1'b0, 1'b1, I_ADD45, 1'b0, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            #1;
            checks++;
            if (ifc.stall !== s[i].hz) begin
                errors++;
                $display("FAIL reset step %0d stall: got %b want %b", i, ifc.stall, s[i].hz);
            end
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL reset step %0d: no expected entry queued", i);
            end else begin
                e = sb.pop_front();
                if (((obs ^ e.val) & e.mask) !== '0) begin
                    errors++;
                    $display("FAIL reset step %0d ex: got %h want %h (mask %h)", i, obs, e.val, e.mask);
                end
            end
        end
    endtask

    task automatic test_decode();
        step_t s[11];
        sb_t   e;
        s = '{'{1'b0, 1'b1, 32'h91001441, 1'b0, 1'b0},   // ADDI
              '{1'b0, 1'b1, 32'hF8000041, 1'b0, 1'b0},   // STUR
              '{1'b0, 1'b1, 32'hB4000001, 1'b0, 1'b0},   // CBZ
              '{1'b0, 1'b1, 32'hAB030041, 1'b0, 1'b0},   // ADDS
              '{1'b0, 1'b1, 32'hF1000441, 1'b0, 1'b0},   // SUBIS
              '{1'b0, 1'b1, 32'h92000041, 1'b0, 1'b0},   // ANDI
              '{1'b0, 1'b1, 32'hCA030041, 1'b0, 1'b0},   // EOR
              '{1'b0, 1'b1, I_LDUR,       1'b0, 1'b0},
              '{1'b0, 1'b1, 32'h14000010, 1'b0, 1'b0},   // B after load: no sources
              '{1'b0, 1'b1, I_LDUR,       1'b0, 1'b0},
              '{1'b0, 1'b1, 32'hB4000002, 1'b0, 1'b0}};  // CBZ X2, no match with X1
        for (int i = 0; i < 11; i++) begin
            apply(s[i]);
            #1;
            checks++;
            if (ifc.stall !== s[i].hz) begin
                errors++;
                $display("FAIL decode step %0d stall: got %b want %b", i, ifc.stall, s[i].hz);
            end
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL decode step %0d: no expected entry queued", i);
            end else begin
                e = sb.pop_front();
                if (((obs ^ e.val) & e.mask) !== '0) begin
                    errors++;
                    $display("FAIL decode step %0d ex: got %h want %h (mask %h)", i, obs, e.val, e.mask);
                end
            end
        end
    endtask

    // Load-use scenarios: plain stall, XZR destination, flush override, STUR Rt
    task automatic test_hazards();
        step_t s[14];
        sb_t   e;
        s = '{'{1'b0, 1'b1, I_LDUR,       1'b0, 1'b0},
              '{1'b0, 1'b1, I_ADD45,      1'b0, 1'b1},
              '{1'b0, 1'b1, I_ADD45,      1'b0, 1'b0},
              '{1'b0, 1'b1, 32'hF840005F, 1'b0, 1'b0},   // LDUR XZR
              '{1'b0, 1'b1, 32'h8B0503E4, 1'b0, 1'b0},
              '{1'b0, 1'b1, I_LDUR,       1'b0, 1'b0},
              '{1'b0, 1'b1, I_ADD45,      1'b1, 1'b0},   // flush wins over hazard
              '{1'b0, 1'b1, I_ADD45,      1'b0, 1'b0},
              '{1'b0, 1'b1, I_LDUR,       1'b0, 1'b0},
              '{1'b0, 1'b1, 32'hF8000041, 1'b0, 1'b1},   // STUR Rt=X1
              '{1'b0, 1'b1, 32'hF8000041, 1'b0, 1'b0},
              '{1'b0, 1'b1, I_LDUR,       1'b0, 1'b0},
              '{1'b0, 1'b0, I_ADD45,      1'b0, 1'b0},   // invalid ID never stalls
              '{1'b0, 1'b1, 32'hB4000001, 1'b0, 1'b0}};  // EX is a bubble now
        for (int i = 0; i < 14; i++) begin
            apply(s[i]);
            #1;
            checks++;
            if (ifc.stall !== s[i].hz) begin
                errors++;
                $display("FAIL hazard step %0d stall: got %b want %b", i, ifc.stall, s[i].hz);
            end
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL hazard step %0d: no expected entry queued", i);
            end else begin
                e = sb.pop_front();
                if (((obs ^ e.val) & e.mask) !== '0) begin
                    errors++;
                    $display("FAIL hazard step %0d ex: got %h want %h (mask %h)", i, obs, e.val, e.mask);
                end
            end
        end
    endtask

    task automatic test_illegal_and_reset_mid_stall();
        step_t s[6];
        sb_t   e;
        s = '{'{1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0},
              '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0},
              '{1'b0, 1'b1, I_LDUR,       1'b0, 1'b0},
              '{1'b1, 1'b1, I_ADD45,      1'b0, 1'b0},   // reset over a pending hazard
              '{1'b0, 1'b1, I_ADD45,      1'b0, 1'b0},
              '{1'b0, 1'b0, I_ADD45,      1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            apply(s[i]);
            #1;
            checks++;
            if (ifc.stall !== s[i].hz) begin
                errors++;
                $display("FAIL illegal/reset step %0d stall: got %b want %b", i, ifc.stall, s[i].hz);
            end
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL illegal/reset step %0d: no expected entry queued", i);
            end else begin
                e = sb.pop_front();
                if (((obs ^ e.val) & e.mask) !== '0) begin
                    errors++;
                    $display("FAIL illegal/reset step %0d ex: got %h want %h (mask %h)", i, obs, e.val, e.mask);
                end
            end
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        ifc.id_valid = 1'b0;
        ifc.id_instr = '0;
        ifc.flush    = 1'b0;
        test_reset();
        test_decode();
        test_hazards();
        test_illegal_and_reset_mid_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_control.md
Name: id_ex_control

Overview:
- Decode and ID/EX pipeline-register stage of the pipelined LEGv8 CPU; sits directly upstream of the ALU control unit.
- Decodes the IF/ID instruction into main control signals and registers them for EX: ALUOp plus opcode field ins[31:21] feed the ALU control unit; the rest feed EX/MEM/WB.
- Detects load-use hazards, requests stalls and inserts bubbles; honours branch flushes.

Parameters:
- XZR, default 31: register index hardwired to zero; never a hazard source.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_instr  in  32  IF/ID instruction word.
- flush  in  1  branch taken; squash the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_ALUOp  out  2  00 LDUR/STUR, 01 CBZ/B, 10 R/I arithmetic/logic.
- ex_ins  out  11  registered id_instr[31:21].
- ex_ALUSrc  out  1  1 = immediate/offset operand B.
- ex_MemRead, ex_MemWrite, ex_MemToReg, ex_RegWrite, ex_SetFlags  out  1 each  standard controls.
- ex_Branch, ex_UncondBr  out  1 each  CBZ / B.
- ex_Rd, ex_Rn, ex_Rm  out  5 each  destination and sources. ex_Rm = id_instr[20:16] for R-type, else id_instr[4:0].
- ex_illegal  out  1  valid instruction with unrecognised opcode.

Behaviour:
- Reset: every registered output is 0 on the first edge with reset=1. stall=0 while reset=1.
- Latency: one cycle from ID to EX outputs.
- Decode (id_instr[31:21], x = don't care):
  - R-type ADD 10001011000, ADDS 10101011000, SUB 11001011000, SUBS 11101011000, AND 10001010000, ORR 10101010000, EOR 11001010000: ALUOp=10, ALUSrc=0, RegWrite=1.
  - I-type ADDI 1001000100x, ADDIS 1011000100x, SUBI 1101000100x, SUBIS 1111000100x, ANDI 1001001000x, ORRI 1011001000x, EORI 1101001000x: ALUOp=10, ALUSrc=1, RegWrite=1.
  - SetFlags=1 only for ADDS, SUBS, ADDIS, SUBIS.
  - LDUR 11111000010: ALUOp=00, ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1.
  - STUR 11111000000: ALUOp=00, ALUSrc=1, MemWrite=1.
  - CBZ (bits[31:24]=10110100): ALUOp=01, Branch=1.
  - B (bits[31:26]=000101): ALUOp=01, UncondBr=1.
  - Anything else: all controls 0, ex_illegal=1, ex_valid=1.
- Source usage (hazard check only):
  - R-type uses Rn and Rm.
  - I-type and LDUR use Rn.
  - STUR uses Rn and Rt [4:0].
  - CBZ uses Rt.
  - B uses none.
- Load-use hazard: hazard = id_valid & ex_valid & ex_MemRead & ex_Rd!=XZR & (ex_Rd matches a used source).
  - stall = hazard & ~flush.
- Next-state priority: reset > flush > hazard > load.
  - flush or hazard: load a bubble. ex_valid=0, all controls 0, ex_ALUOp=00, ex_illegal=0; register fields don't care.
  - id_valid=0: bubble.
  - Otherwise: load the decoded instruction.
- Stalled instruction: IF/ID holds it, EX is now a bubble, so it proceeds the next cycle. A load-use stall lasts exactly 1 cycle.
- flush and hazard in the same cycle: bubble, stall=0.
- Reset asserted mid-stall: outputs clear next edge; no residual stall.

Test Plan:
- Reset held 2 cycles with id_instr=0x8B030041, id_valid=1 -> all ex_* 0 and stall 0 throughout; first edge after release gives ex_valid=1, ALUOp=10, ex_ins=10001011000, Rd=1, Rn=2, Rm=3, RegWrite=1.
- ADDI 0x91001441, then STUR 0xF8000041, then CBZ 0xB4000001 -> respectively:
  - ALUOp=10, ALUSrc=1
  - ALUOp=00, MemWrite=1, RegWrite=0, Rm=1
  - ALUOp=01, Branch=1
- LDUR 0xF8400041 then ADD X4,X1,X5 0x8B050024 -> stall=1 for one cycle and EX bubble (ex_valid=0); the next cycle ADD enters EX with Rd=4, Rn=1, Rm=5, and stall=0.
- LDUR to XZR 0xF840005F then 0x8B0503E4 -> no stall; back-to-back EX valid.
- LDUR 0xF8400041 then 0x8B050024 with flush=1 in the hazard cycle -> stall=0, bubble loaded.
- Unknown opcode 0x00000000 with id_valid=1 -> ex_valid=1, ex_illegal=1, all writes 0.
